bus_change_logger: RTL and testbench

Synthesizable event logger for a narrow input bus: synchronizes the bus, detects every value change, timestamps it, and queues `{time, value}` records in a small FIFO for a downstream consumer over a valid/ready handshake. It sits between the pad-side input pins and the debug/overlay logic in the VGA design, and replaces simulation-only `$display` change tracing with hardware that can be observed on silicon.

---
 rtl/bus_change_logger_pkg.sv | 21 ++
 rtl/bus_change_logger_event_fifo.sv | 53 +++++
 rtl/bus_change_logger.sv | 95 +++++++++
 tb/tb_bus_change_logger.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_change_logger_pkg.sv
// Shared defaults and record layout for the bus change logger.
// Records are {time, data}: timestamp in the MSBs, bus value in the LSBs.
package bus_change_logger_pkg;

  localparam int unsigned WIDTH_DEF   = 2;
  localparam int unsigned TS_BITS_DEF = 16;
  localparam int unsigned DEPTH_DEF   = 4;

  // Bit offset of the data field inside a record; the timestamp sits directly above it.
  localparam int unsigned REC_DATA_LSB = 0;

  typedef struct packed {
    logic [TS_BITS_DEF-1:0] ts;
    logic [WIDTH_DEF-1:0]   data;
  } ev_rec_t;

  function automatic int unsigned rec_bits(input int unsigned width, input int unsigned ts_bits);
    return width + ts_bits;
  endfunction

endpackage

// File: rtl/bus_change_logger_event_fifo.sv
// Show-ahead FIFO for change records; head is readable whenever not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module event_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_pop_c;
  logic          do_push_c;

  assign empty = (wr_q == rd_q);
  assign count = wr_q - rd_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    do_pop_c  = pop && !empty;
    do_push_c = push && (!full || do_pop_c);
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (do_push_c) wr_d = wr_q + (AW+1)'(1);
    if (do_pop_c)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push_c) mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/bus_change_logger.sv
// Synchronizes a narrow bus, timestamps every value change and queues
// {time, value} records for a valid/ready consumer.
module bus_change_logger
  import bus_change_logger_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TS_BITS = TS_BITS_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          a_in,
  input  logic                      enable,
  input  logic                      ev_ready,
  input  logic                      clr_ovf,
  output logic                      ev_valid,
  output logic [WIDTH-1:0]          ev_data,
  output logic [TS_BITS-1:0]        ev_time,
  output logic [$clog2(DEPTH):0]    ev_count,
  output logic                      ev_overflow
);

  localparam int unsigned RW = rec_bits(WIDTH, TS_BITS);

  typedef struct packed {
    logic [TS_BITS-1:0] ts;
    logic [WIDTH-1:0]   data;
  } rec_t;

  logic [WIDTH-1:0]   s1_q, s2_q, prev_q;
  logic [TS_BITS-1:0] ts_q, ts_d;
  logic               ovf_q, ovf_d;
  logic               chg_c;
  logic               push_c;
  logic               pop_fire_c;
  logic               full_c;
  logic               empty_c;
  logic [RW-1:0]      push_rec_c;
  logic [RW-1:0]      head_c;
  rec_t               push_fields_c;
  rec_t               head_fields_c;

  // prev follows s2 regardless of enable, so changes made while disabled are absorbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= a_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      ts_q   <= ts_d;
      ovf_q  <= ovf_d;
    end
  end

  // A drop sets the sticky flag and wins over a same-edge clear.
  always_comb begin
    chg_c              = (s2_q != prev_q);
    push_c             = chg_c && enable;
    pop_fire_c         = !empty_c && ev_ready;
    ts_d               = enable ? ts_q + TS_BITS'(1) : ts_q;
    ovf_d              = ovf_q;
    push_fields_c.ts   = ts_q;
    push_fields_c.data = s2_q;
    push_rec_c         = push_fields_c;
    if (clr_ovf) ovf_d = 1'b0;
    if (push_c && full_c && !pop_fire_c) ovf_d = 1'b1;
  end

  event_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_rec_c),
    .pop       (ev_ready),
    .head      (head_c),
    .count     (ev_count),
    .full      (full_c),
    .empty     (empty_c)
  );

  assign head_fields_c = head_c;
  assign ev_valid      = !empty_c;
  assign ev_data       = head_fields_c.data;
  assign ev_time       = head_fields_c.ts;
  assign ev_overflow   = ovf_q;

endmodule

// File: tb/tb_bus_change_logger.sv
// Directed bench for bus_change_logger with immediate-assertion checks.
module tb_bus_change_logger;

  logic        clk;
  logic        reset;
  logic [1:0]  a_in;
  logic        enable;
  logic        ev_ready;
  logic        clr_ovf;
  logic        ev_valid;
  logic [1:0]  ev_data;
  logic [15:0] ev_time;
  logic [2:0]  ev_count;
  logic        ev_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int ts_m  = 0;
  int q_time[$];
  int q_data[$];

  bus_change_logger #(.WIDTH(2), .TS_BITS(16), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_in        (a_in),
    .enable      (enable),
    .ev_ready    (ev_ready),
    .clr_ovf     (clr_ovf),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_time     (ev_time),
    .ev_count    (ev_count),
    .ev_overflow (ev_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; ts_m mirrors the expected timestamp counter.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset) ts_m = 0;
      else if (enable) ts_m++;
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; a_in = 2'b00; enable = 1'b1; ev_ready = 1'b0; clr_ovf = 1'b0;
    step(3);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_data",  32'(ev_data),  32'd0);
    check("rst_time",  32'(ev_time),  32'd0);
    check("rst_count", 32'(ev_count), 32'd0);
    check("rst_ovf",   32'(ev_overflow), 32'd0);

    // Basic latency: change sampled at edge 5, logged at edge 7 with time 6
    reset = 1'b0;
    step(4);
    a_in = 2'b01;
    step(2);
    check("lat_valid_e6", 32'(ev_valid), 32'd0);
    step(1);
    check("lat_valid_e7", 32'(ev_valid), 32'd1);
    check("lat_data",  32'(ev_data),  32'd1);
    check("lat_time",  32'(ev_time),  32'd6);
    check("lat_count", 32'(ev_count), 32'd1);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check("lat_pop_valid", 32'(ev_valid), 32'd0);
    check("lat_pop_count", 32'(ev_count), 32'd0);

    // Nonzero value held through reset gives exactly one event
    a_in = 2'b11; reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    check("hold_valid_e2", 32'(ev_valid), 32'd0);
    step(1);
    check("hold_valid_e3", 32'(ev_valid), 32'd1);
    check("hold_data",  32'(ev_data),  32'd3);
    check("hold_time",  32'(ev_time),  32'd2);
    step(5);
    check("hold_count", 32'(ev_count), 32'd1);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check("hold_drain", 32'(ev_count), 32'd0);

    // Overflow: six changes two clocks apart with no consumer
    reset = 1'b1; a_in = 2'b00;
    step(2);
    reset = 1'b0;
    step(2);
    for (int i = 0; i < 6; i++) begin
      a_in = a_in ^ 2'b01;
      step(2);
      check("ovf_count", 32'(ev_count), 32'((i < 4) ? i : 4));
      check("ovf_flag",  32'(ev_overflow), 32'((i >= 5) ? 1 : 0));
    end
    step(2);
    check("ovf_count_end", 32'(ev_count), 32'd4);
    check("ovf_flag_end",  32'(ev_overflow), 32'd1);
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(ev_valid), 32'd1);
      check("drain_data",  32'(ev_data), 32'((k % 2 == 0) ? 1 : 0));
      check("drain_time",  32'(ev_time), 32'(4 + 2 * k));
      step(1);
    end
    ev_ready = 1'b0;
    check("drain_empty", 32'(ev_valid), 32'd0);
    check("drain_ovf_sticky", 32'(ev_overflow), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(ev_overflow), 32'd0);

    // Full FIFO with pop on the same edge as a new push
    for (int i = 0; i < 4; i++) begin
      a_in = a_in ^ 2'b01;
      q_time.push_back(ts_m + 2);
      q_data.push_back(int'(a_in));
      step(2);
    end
    step(1);
    check("full_count", 32'(ev_count), 32'd4);
    a_in = a_in ^ 2'b01;
    q_time.push_back(ts_m + 2);
    q_data.push_back(int'(a_in));
    step(2);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    void'(q_time.pop_front());
    void'(q_data.pop_front());
    check("swap_count", 32'(ev_count), 32'd4);
    check("swap_ovf",   32'(ev_overflow), 32'd0);
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("swap_data", 32'(ev_data), 32'(q_data[k]));
      check("swap_time", 32'(ev_time), 32'(q_time[k]));
      step(1);
    end
    ev_ready = 1'b0;
    check("swap_empty", 32'(ev_count), 32'd0);

    // Disabled: no capture, timestamp frozen, no event on re-enable
    enable = 1'b0;
    a_in = 2'b00;
    step(3);
    a_in = 2'b10;
    step(5);
    check("dis_count", 32'(ev_count), 32'd0);
    enable = 1'b1;
    step(4);
    check("reen_count", 32'(ev_count), 32'd0);
    a_in = 2'b11;
    q_time.delete();
    q_time.push_back(ts_m + 2);
    step(3);
    check("reen_valid", 32'(ev_valid), 32'd1);
    check("reen_data",  32'(ev_data),  32'd3);
    check("reen_time",  32'(ev_time),  32'(q_time[0]));

    // Asynchronous reset with records queued
    a_in = 2'b10;
    step(2);
    a_in = 2'b11;
    step(3);
    check("pre_rst_count", 32'(ev_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(ev_valid), 32'd0);
    check("arst_count", 32'(ev_count), 32'd0);
    check("arst_ovf",   32'(ev_overflow), 32'd0);
    #1 reset = 1'b0;
    ts_m = 0;
    step(2);
    check("post_rst_e2", 32'(ev_valid), 32'd0);
    step(1);
    check("post_rst_valid", 32'(ev_valid), 32'd1);
    check("post_rst_data",  32'(ev_data),  32'd3);
    check("post_rst_time",  32'(ev_time),  32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
